// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types, widths and winner codes for the guessing-round controller
package guess_pkg;
  localparam int GUESS_W = 7;
  localparam int TRIES_W = 4;
  localparam logic [GUESS_W-1:0] GUESS_MAX = 7'd99;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_LOST = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TURN_A,
    S_TURN_B,
    S_CHECK,
    S_DONE
  } state_t;

  function automatic logic [TRIES_W-1:0] sat_inc(input logic [TRIES_W-1:0] v);
    return (v == '1) ? v : v + TRIES_W'(1);
  endfunction
endpackage

// File: rtl/guess_turn_timer.sv
// rtl/guess_turn_timer.sv - per-turn tick countdown; expire flags the tick that would reach zero
module guess_turn_timer #(
  parameter int TURN_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);
  localparam logic [7:0] RELOAD = 8'(TURN_TICKS);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || load)
      count <= RELOAD;
    else if (tick && count != 8'd0)
      count <= count - 8'd1;
  end

  assign expire = tick && (count == 8'd1);
endmodule

// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - two-player number-guessing round FSM with shared comparator
// Optional win scoring is built only when GUESS_SCORE_EN is defined.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int MAX_TRIES  = 8,
  parameter int TURN_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [GUESS_W-1:0] secret,
  input  logic               secret_load,
  input  logic [GUESS_W-1:0] guess_a,
  input  logic [GUESS_W-1:0] guess_b,
  input  logic               submit_a,
  input  logic               submit_b,
  output logic               grant_a,
  output logic               grant_b,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic [TRIES_W-1:0] tries,
  output logic [1:0]         winner,
  output logic               busy,
  output logic [3:0]         score_a,
  output logic [3:0]         score_b
);
  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_t             state;
  logic [GUESS_W-1:0] secret_q;
  logic [GUESS_W-1:0] guess_q;
  logic               from_b;

  logic turn_a, turn_b, submit_ok, expire, tmr_load;
  logic cmp_lt, cmp_eq, cmp_gt;
  logic [TRIES_W-1:0] tries_nx;

  assign turn_a    = (state == S_TURN_A);
  assign turn_b    = (state == S_TURN_B);
  assign submit_ok = (turn_a && submit_a && guess_a <= GUESS_MAX) ||
                     (turn_b && submit_b && guess_b <= GUESS_MAX);
  // Held in reload outside a turn, and reloaded on a forfeit hand-over.
  assign tmr_load  = !(turn_a || turn_b) || expire;

  assign cmp_lt   = guess_q < secret_q;
  assign cmp_eq   = guess_q == secret_q;
  assign cmp_gt   = guess_q > secret_q;
  assign tries_nx = sat_inc(tries);

  guess_turn_timer #(.TURN_TICKS(TURN_TICKS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .tick   (tick),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      from_b   <= 1'b0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      res_lt   <= 1'b0;
      res_eq   <= 1'b0;
      res_gt   <= 1'b0;
      tries    <= '0;
      winner   <= WIN_NONE;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_ARM;
          busy  <= 1'b1;
        end
        S_ARM: if (secret_load && secret <= GUESS_MAX) begin
          secret_q <= secret;
          tries    <= '0;
          res_lt   <= 1'b0;
          res_eq   <= 1'b0;
          res_gt   <= 1'b0;
          winner   <= WIN_NONE;
          grant_a  <= 1'b1;
          state    <= S_TURN_A;
        end
        S_TURN_A, S_TURN_B: begin
          if (submit_ok) begin
            guess_q <= turn_b ? guess_b : guess_a;
            from_b  <= turn_b;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            state   <= S_CHECK;
          end else if (expire) begin
            tries   <= tries_nx;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            if (tries_nx >= MAX_T) begin
              winner <= WIN_LOST;
              state  <= S_DONE;
            end else begin
              grant_a <= turn_b;
              grant_b <= turn_a;
              state   <= turn_b ? S_TURN_A : S_TURN_B;
            end
          end
        end
        S_CHECK: begin
          tries  <= tries_nx;
          res_lt <= cmp_lt;
          res_eq <= cmp_eq;
          res_gt <= cmp_gt;
          if (cmp_eq) begin
            winner <= from_b ? WIN_B : WIN_A;
            state  <= S_DONE;
          end else if (tries_nx >= MAX_T) begin
            winner <= WIN_LOST;
            state  <= S_DONE;
          end else begin
            grant_a <= from_b;
            grant_b <= !from_b;
            state   <= from_b ? S_TURN_A : S_TURN_B;
          end
        end
        S_DONE: if (start) state <= S_ARM;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GUESS_SCORE_EN
  logic [3:0] score_a_q, score_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      score_a_q <= '0;
      score_b_q <= '0;
    end else if (state == S_CHECK && cmp_eq) begin
      if (from_b) score_b_q <= sat_inc(score_b_q);
      else        score_a_q <= sat_inc(score_a_q);
    end
  end

  assign score_a = score_a_q;
  assign score_b = score_b_q;
`else
  assign score_a = 4'd0;
  assign score_b = 4'd0;
`endif
endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb/tb_guess_round_ctrl.sv - directed scoreboard bench for guess_round_ctrl (two parameter sets)
module tb_guess_round_ctrl;
`ifdef GUESS_SCORE_EN
  localparam logic [3:0] SC = 4'd1;
`else
  localparam logic [3:0] SC = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, start, secret_load, submit_a, submit_b;
  logic [6:0] secret, guess_a, guess_b;

  logic       ga1, gb1, lt1, eq1, gt1, busy1;
  logic [3:0] tries1, sa1, sb1;
  logic [1:0] win1;
  logic       ga2, gb2, lt2, eq2, gt2, busy2;
  logic [3:0] tries2, sa2, sb2;
  logic [1:0] win2;

  always #5 clk = ~clk;

  guess_round_ctrl #(.MAX_TRIES(8), .TURN_TICKS(10)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .secret(secret),
    .secret_load(secret_load), .guess_a(guess_a), .guess_b(guess_b),
    .submit_a(submit_a), .submit_b(submit_b), .grant_a(ga1), .grant_b(gb1),
    .res_lt(lt1), .res_eq(eq1), .res_gt(gt1), .tries(tries1), .winner(win1),
    .busy(busy1), .score_a(sa1), .score_b(sb1)
  );

  guess_round_ctrl #(.MAX_TRIES(2), .TURN_TICKS(3)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .secret(secret),
    .secret_load(secret_load), .guess_a(guess_a), .guess_b(guess_b),
    .submit_a(submit_a), .submit_b(submit_b), .grant_a(ga2), .grant_b(gb2),
    .res_lt(lt2), .res_eq(eq2), .res_gt(gt2), .tries(tries2), .winner(win2),
    .busy(busy2), .score_a(sa2), .score_b(sb2)
  );

  typedef struct {
    string       tag;
    bit          on2;
    logic [19:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  function automatic logic [19:0] pk(input logic ga, input logic gb, input logic lt,
                                     input logic eq, input logic gt, input logic [3:0] tr,
                                     input logic [1:0] w, input logic b, input logic [3:0] sa,
                                     input logic [3:0] sb);
    return {ga, gb, lt, eq, gt, tr, w, b, sa, sb};
  endfunction

  task automatic push(input string tag, input bit on2, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.on2 = on2;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [19:0] o;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e = sb_q.pop_front();
      o = e.on2 ? pk(ga2, gb2, lt2, eq2, gt2, tries2, win2, busy2, sa2, sb2)
                : pk(ga1, gb1, lt1, eq1, gt1, tries1, win1, busy1, sa1, sb1);
      assert (o === e.v) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%05h expected=%05h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load(input logic [6:0] v);
    secret      = v;
    secret_load = 1'b1;
    step();
    secret_load = 1'b0;
  endtask

  task automatic sub_a(input logic [6:0] v);
    guess_a  = v;
    submit_a = 1'b1;
    step();
    submit_a = 1'b0;
  endtask

  task automatic sub_b(input logic [6:0] v);
    guess_b  = v;
    submit_b = 1'b1;
    step();
    submit_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; secret_load = 1'b0;
    submit_a = 1'b0; submit_b = 1'b0; secret = '0; guess_a = '0; guess_b = '0;
    step();
    push("reset_d1", 0, pk(0,0,0,0,0,0,2'b00,0,0,0));
    push("reset_d2", 1, pk(0,0,0,0,0,0,2'b00,0,0,0));
    rst = 1'b0;
    step();
    check(); check();

    // Immediate win by A
    push("s1_arm", 0, pk(0,0,0,0,0,0,2'b00,1,0,0));
    pulse_start(); check();
    push("s1_turn_a", 0, pk(1,0,0,0,0,0,2'b00,1,0,0));
    load(7'd42); check();
    push("s1_check", 0, pk(0,0,0,0,0,0,2'b00,1,0,0));
    sub_a(7'd42); check();
    push("s1_done", 0, pk(0,0,0,1,0,1,2'b01,1,SC,0));
    step(); check();
    push("s1_hold", 0, pk(0,0,0,1,0,1,2'b01,1,SC,0));
    step(); check();

    // New round from DONE: lt, gt, eq
    push("s2_arm_hold", 0, pk(0,0,0,1,0,1,2'b01,1,SC,0));
    pulse_start(); check();
    push("s2_turn_a", 0, pk(1,0,0,0,0,0,2'b00,1,SC,0));
    load(7'd42); check();
    push("s2_chk_a", 0, pk(0,0,0,0,0,0,2'b00,1,SC,0));
    sub_a(7'd30); check();
    push("s2_lt", 0, pk(0,1,1,0,0,1,2'b00,1,SC,0));
    step(); check();
    push("s2_chk_b", 0, pk(0,0,1,0,0,1,2'b00,1,SC,0));
    sub_b(7'd50); check();
    push("s2_gt", 0, pk(1,0,0,0,1,2,2'b00,1,SC,0));
    step(); check();
    push("s2_eq", 0, pk(0,0,0,1,0,3,2'b01,1,SC+SC,0));
    sub_a(7'd42); step(); check();

    // MAX_TRIES=2 instance: round lost
    do_rst();
    pulse_start();
    push("s3_turn_a", 1, pk(1,0,0,0,0,0,2'b00,1,0,0));
    load(7'd10); check();
    push("s3_turn_b", 1, pk(0,1,1,0,0,1,2'b00,1,0,0));
    sub_a(7'd5); step(); check();
    push("s3_lost", 1, pk(0,0,1,0,0,2,2'b11,1,0,0));
    sub_b(7'd5); step(); check();

    // TURN_TICKS=3 instance: forfeit, then submit beats final tick
    do_rst();
    pulse_start();
    load(7'd42);
    tick = 1'b1;
    push("s4_two_ticks", 1, pk(1,0,0,0,0,0,2'b00,1,0,0));
    step(); step(); check();
    push("s4_forfeit", 1, pk(0,1,0,0,0,1,2'b00,1,0,0));
    step(); tick = 1'b0; check();
    tick = 1'b1;
    step(); step();
    guess_b = 7'd50; submit_b = 1'b1;
    push("s4_submit_wins", 1, pk(0,0,0,0,0,1,2'b00,1,0,0));
    step(); tick = 1'b0; submit_b = 1'b0; check();
    push("s4_gt_lost", 1, pk(0,0,0,0,1,2,2'b11,1,0,0));
    step(); check();

    // Ignored inputs: bad secret, wrong-player submit, out-of-range guess
    do_rst();
    pulse_start();
    push("s5_bad_secret", 0, pk(0,0,0,0,0,0,2'b00,1,0,0));
    load(7'd120); check();
    push("s5_turn_a", 0, pk(1,0,0,0,0,0,2'b00,1,0,0));
    load(7'd42); check();
    push("s5_b_ignored", 0, pk(1,0,0,0,0,0,2'b00,1,0,0));
    sub_b(7'd42); check();
    push("s5_a_reject", 0, pk(1,0,0,0,0,0,2'b00,1,0,0));
    sub_a(7'd120); check();
    push("s5_still_a", 0, pk(1,0,0,0,0,0,2'b00,1,0,0));
    step(); check();
    push("s5_turn_b", 0, pk(0,1,1,0,0,1,2'b00,1,0,0));
    sub_a(7'd10); step(); check();

    // Reset mid-round from TURN_B
    push("s6_rst", 0, pk(0,0,0,0,0,0,2'b00,0,0,0));
    do_rst(); check();
    push("s6_idle", 0, pk(0,0,0,0,0,0,2'b00,0,0,0));
    sub_b(7'd42); check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
